// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with valid/ready output register, error flags, overrun and break.
// Define UART_RX_MAJORITY_EN to take each bit as a 2-of-3 vote around the mid-bit point.
module uart_rx_param #(
  parameter int unsigned CLK_RATE  = 50000000,
  parameter int unsigned BR        = 9600,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned PARITY    = 1,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              serial_in,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              parity_error,
  output logic              frame_error,
  output logic              overrun,
  output logic              break_det,
  output logic              busy
);

  localparam int unsigned Cpb     = CLK_RATE / BR;
  localparam int unsigned CntW    = $clog2(Cpb) + 1;
  localparam int unsigned BitW    = $clog2(DATA_W + 1);
  localparam int unsigned HalfCnt = (Cpb - 1) / 2;
`ifdef UART_RX_MAJORITY_EN
  localparam int unsigned MajOff  = 1;
`else
  localparam int unsigned MajOff  = 0;
`endif
  // Decision points sit MajOff past the mid-bit count; reload keeps timing referenced to it.
  localparam logic [CntW-1:0] StartPt = CntW'(HalfCnt + MajOff);
  localparam logic [CntW-1:0] BitPt   = CntW'(Cpb - 1 + MajOff);
  localparam logic [CntW-1:0] Reload  = CntW'(MajOff);
  localparam logic [BitW-1:0] LastBit  = BitW'(DATA_W - 1);
  localparam logic [BitW-1:0] LastStop = BitW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    StIdle, StStart, StData, StParity, StStop, StDone, StBreak
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        sync_q;
  logic              rxs;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [BitW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_bit_q, par_bit_d;
  logic              perr_q, perr_d;
  logic              ferr_q, ferr_d;
  logic              brk_q, brk_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              perr_out_q, perr_out_d;
  logic              ferr_out_q, ferr_out_d;
  logic              ovr_q, ovr_d;
  logic              bit_val;
  logic              sample_pt;
  logic              exp_par;
  logic              is_break;
  logic              complete;

  assign rxs = sync_q[1];

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) hist_q <= 2'b11;
    else          hist_q <= {hist_q[0], rxs};
  end

  assign bit_val = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxs) | (hist_q[0] & rxs);
`else
  assign bit_val = rxs;
`endif

  assign exp_par  = (^shift_q) ^ (PARITY == 2);
  assign is_break = ferr_q && (shift_q == '0) && !par_bit_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_bit_d = par_bit_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    brk_d     = 1'b0;
    complete  = 1'b0;
    sample_pt = (state_q == StStart) ? (cnt_q == StartPt) : (cnt_q == BitPt);
    unique case (state_q)
      StIdle: begin
        cnt_d     = '0;
        bit_cnt_d = '0;
        par_bit_d = 1'b0;
        perr_d    = 1'b0;
        ferr_d    = 1'b0;
        if (!rxs) state_d = StStart;
      end
      StStart: begin
        if (sample_pt) begin
          cnt_d   = Reload;
          state_d = bit_val ? StIdle : StData;
        end
      end
      StData: begin
        if (sample_pt) begin
          cnt_d     = Reload;
          shift_d   = {bit_val, shift_q[DATA_W-1:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LastBit) begin
            bit_cnt_d = '0;
            state_d   = (PARITY != 0) ? StParity : StStop;
          end
        end
      end
      StParity: begin
        if (sample_pt) begin
          cnt_d     = Reload;
          par_bit_d = bit_val;
          perr_d    = (bit_val != exp_par);
          state_d   = StStop;
        end
      end
      StStop: begin
        if (sample_pt) begin
          cnt_d     = Reload;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (!bit_val) ferr_d = 1'b1;
          if (bit_cnt_q == LastStop) begin
            bit_cnt_d = '0;
            state_d   = StDone;
          end
        end
      end
      StDone: begin
        cnt_d = '0;
        if (is_break) begin
          brk_d   = 1'b1;
          state_d = StBreak;
        end else begin
          complete = 1'b1;
          state_d  = (ferr_q && !rxs) ? StBreak : StIdle;
        end
      end
      StBreak: begin
        cnt_d = '0;
        if (rxs) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Acceptance and a new completion may coincide: the new word replaces the accepted one.
  always_comb begin
    valid_d    = valid_q;
    data_out_d = data_out_q;
    perr_out_d = perr_out_q;
    ferr_out_d = ferr_out_q;
    ovr_d      = ovr_q;
    if (valid_q && rx_ready) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
    if (complete) begin
      if (!valid_q || rx_ready) begin
        valid_d    = 1'b1;
        data_out_d = shift_q;
        perr_out_d = perr_q;
        ferr_out_d = ferr_q;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q     <= 2'b11;
      state_q    <= StIdle;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_bit_q  <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      brk_q      <= 1'b0;
      valid_q    <= 1'b0;
      data_out_q <= '0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], serial_in};
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_bit_q  <= par_bit_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      brk_q      <= brk_d;
      valid_q    <= valid_d;
      data_out_q <= data_out_d;
      perr_out_q <= perr_out_d;
      ferr_out_q <= ferr_out_d;
      ovr_q      <= ovr_d;
    end
  end

  assign rx_data      = data_out_q;
  assign rx_valid     = valid_q;
  assign parity_error = perr_out_q;
  assign frame_error  = ferr_out_q;
  assign overrun      = ovr_q;
  assign break_det    = brk_q;
  assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: CPB=16, 8 data bits, even parity, one stop bit.
module tb_uart_rx_param;

  localparam int unsigned Cpb = 16;
`ifdef UART_RX_MAJORITY_EN
  localparam bit Glitch = 1'b1;
`else
  localparam bit Glitch = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } word_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       serial_in = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, parity_error, frame_error, overrun, break_det, busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_rx_param #(
    .CLK_RATE (160000),
    .BR       (10000),
    .DATA_W   (8),
    .PARITY   (1),
    .STOP_BITS(1)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .serial_in   (serial_in),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .parity_error(parity_error),
    .frame_error (frame_error),
    .overrun     (overrun),
    .break_det   (break_det),
    .busy        (busy)
  );

  // Monitor: records handshakes and pulse counts on the falling edge.
  word_t got_q[$];
  int    cyc = 0;
  int    valid_cycles = 0;
  int    brk_pulses = 0;
  int    busy_cycles = 0;
  int    rise_cyc = 0;
  logic  valid_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid && rx_ready) got_q.push_back({rx_data, parity_error, frame_error});
    if (rx_valid) valid_cycles <= valid_cycles + 1;
    if (rx_valid && !valid_prev) rise_cyc <= cyc;
    valid_prev <= rx_valid;
    if (break_det) brk_pulses <= brk_pulses + 1;
    if (busy) busy_cycles <= busy_cycles + 1;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic v, input bit glitch);
    for (int i = 0; i < Cpb; i++) begin
      serial_in = (glitch && i == 8) ? ~v : v;
      tick(1);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit flip_par, input bit bad_stop,
                            input bit glitch);
    logic par;
    par = (^d) ^ flip_par;
    drive_bit(1'b0, glitch);
    for (int i = 0; i < 8; i++) drive_bit(d[i], glitch);
    drive_bit(par, glitch);
    drive_bit(!bad_stop, glitch);
    serial_in = 1'b1;
  endtask

  // Reference: a frame is a break when its stop is bad and every data and parity bit is 0.
  function automatic bit model_break(input logic [7:0] d, input bit flip_par, input bit bad_stop);
    return bad_stop && (d == 8'h00) && (((^d) ^ flip_par) == 1'b0);
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    tick(4);
    checks++;
    if (rx_data !== 8'h00) begin
      errors++; $display("FAIL reset_data: got %h expected 00", rx_data);
    end
    checks++;
    if ({rx_valid, parity_error, frame_error, overrun, break_det} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 00000",
               {rx_valid, parity_error, frame_error, overrun, break_det});
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b expected 0", busy);
    end
    reset_n = 1'b1;
    tick(20);
    checks++;
    if ({rx_valid, busy} !== 2'b00) begin
      errors++; $display("FAIL idle_after_reset: got %b expected 00", {rx_valid, busy});
    end
  endtask

  task automatic test_basic();
    int v0, st, lat;
    rx_ready = 1'b1;
    got_q.delete();
    v0 = valid_cycles;
    st = cyc;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
    tick(8);
    checks++;
    if (got_q.size() != 1) begin
      errors++; $display("FAIL basic_count: got %0d expected 1", got_q.size());
    end else begin
      checks++;
      if (got_q[0] !== {8'hA5, 1'b0, 1'b0}) begin
        errors++; $display("FAIL basic_word: got %h expected %h", got_q[0], {8'hA5, 2'b00});
      end
    end
    checks++;
    if (valid_cycles - v0 != 1) begin
      errors++; $display("FAIL basic_pulse: got %0d expected 1", valid_cycles - v0);
    end
    lat = rise_cyc - st;
    checks++;
    if (lat < 165 || lat > 180) begin
      errors++; $display("FAIL basic_latency: got %0d expected 165..180", lat);
    end
  endtask

  task automatic test_parity();
    got_q.delete();
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    tick(8);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== {8'hA5, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL parity_word: got n=%0d %h expected n=1 %h", got_q.size(),
               (got_q.size() > 0) ? got_q[0] : 10'h0, {8'hA5, 2'b10});
    end
  endtask

  task automatic test_back_to_back();
    rx_ready = 1'b0;
    got_q.delete();
    send_frame(8'h11, 1'b0, 1'b0, 1'b0);
    send_frame(8'h22, 1'b0, 1'b0, 1'b0);
    tick(8);
    checks++;
    if ({rx_valid, rx_data, overrun} !== {1'b1, 8'h11, 1'b1}) begin
      errors++;
      $display("FAIL overrun_hold: got v=%b d=%h o=%b expected v=1 d=11 o=1",
               rx_valid, rx_data, overrun);
    end
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    tick(3);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== {8'h11, 1'b0, 1'b0}) begin
      errors++; $display("FAIL overrun_deliver: got n=%0d expected one word 11", got_q.size());
    end
    checks++;
    if ({rx_valid, overrun} !== 2'b00) begin
      errors++; $display("FAIL overrun_clear: got %b expected 00", {rx_valid, overrun});
    end
    rx_ready = 1'b1;
  endtask

  task automatic test_glitch();
    int v0, b0;
    v0 = valid_cycles;
    b0 = busy_cycles;
    serial_in = 1'b0;
    tick(4);
    serial_in = 1'b1;
    tick(40);
    checks++;
    if (busy_cycles == b0) begin
      errors++; $display("FAIL glitch_busy_seen: got 0 busy cycles expected >0");
    end
    checks++;
    if ({busy, rx_valid} !== 2'b00 || valid_cycles != v0) begin
      errors++;
      $display("FAIL glitch_abort: got busy=%b valid_cycles=%0d expected 0 and %0d",
               busy, valid_cycles, v0);
    end
  endtask

  task automatic test_break();
    int v0, k0;
    v0 = valid_cycles;
    k0 = brk_pulses;
    got_q.delete();
    serial_in = 1'b0;
    tick(15 * Cpb);
    serial_in = 1'b1;
    tick(3 * Cpb);
    checks++;
    if (brk_pulses - k0 != 1 || valid_cycles != v0) begin
      errors++;
      $display("FAIL break_pulse: got pulses=%0d valid=%0d expected 1 and 0",
               brk_pulses - k0, valid_cycles - v0);
    end
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    tick(8);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== {8'h3C, 1'b0, 1'b0}) begin
      errors++; $display("FAIL break_recover: got n=%0d expected one word 3C", got_q.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    d = 8'h55;
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i], 1'b0);
    tick(5);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL mid_busy: got %b expected 1", busy);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({rx_data, rx_valid, parity_error, frame_error, overrun, break_det, busy} !== 14'h0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got d=%h flags=%b expected all 0", rx_data,
               {rx_valid, parity_error, frame_error, overrun, break_det, busy});
    end
    serial_in = 1'b1;
    tick(3);
    reset_n = 1'b1;
    tick(10);
    got_q.delete();
    send_frame(8'h0F, 1'b0, 1'b0, Glitch);
    tick(8);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== {8'h0F, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL mid_recover: got n=%0d %h expected one word %h", got_q.size(),
               (got_q.size() > 0) ? got_q[0] : 10'h0, {8'h0F, 2'b00});
    end
  endtask

  task automatic test_random();
    logic [7:0] d;
    bit         flip, bad, brk;
    int         k0;
    word_t      exp_w;
    rx_ready = 1'b1;
    for (int n = 0; n < 20; n++) begin
      d    = 8'($urandom);
      if ($urandom_range(7) == 0) d = 8'h00;
      flip = ($urandom_range(3) == 0);
      bad  = ($urandom_range(3) == 0);
      brk  = model_break(d, flip, bad);
      exp_w = {d, flip, bad};
      got_q.delete();
      k0 = brk_pulses;
      send_frame(d, flip, bad, 1'b0);
      tick(2 * Cpb);
      checks++;
      if (brk) begin
        if (got_q.size() != 0 || brk_pulses - k0 != 1) begin
          errors++;
          $display("FAIL rand_break[%0d]: got n=%0d pulses=%0d expected 0 and 1", n,
                   got_q.size(), brk_pulses - k0);
        end
      end else begin
        if (got_q.size() != 1 || got_q[0] !== exp_w || brk_pulses != k0) begin
          errors++;
          $display("FAIL rand_word[%0d]: got n=%0d %h expected n=1 %h", n, got_q.size(),
                   (got_q.size() > 0) ? got_q[0] : 10'h0, exp_w);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_back_to_back();
    test_glitch();
    test_break();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
